// File: rtl/camera_pkg.sv
// Shared definitions for the camera stream conditioner.
// DATA_W is the pixel width and matches video_ext_PIXEL_DATA.
// H_ACTIVE_DEF and V_ACTIVE_DEF are the default D5M geometry (640x480).
// POS_X_W and POS_Y_W are the widths of the reported peak position.
// state_t holds the frame FSM states.
package camera_pkg;
  localparam int DATA_W       = 12;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int POS_X_W      = 10;
  localparam int POS_Y_W      = 9;

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;
endpackage

// File: rtl/peak_pixel_tracker.sv
// Tracks the brightest pixel at or above thresh within one frame.
// The comparison is strict, so on ties the first pixel in raster order wins.
// Ports:
//   clk, reset_n         clock and asynchronous active-low reset
//   clear                start of a new frame; forgets the previous peak
//   sample               pixel strobe (pixel is inside the active window)
//   data, x, y           pixel value and its position
//   thresh               minimum level a pixel needs to qualify
//   max_val/max_x/max_y  current peak value and its position
//   found                at least one pixel qualified since the last clear
module peak_pixel_tracker
  import camera_pkg::*;
#(
  parameter int X_W = POS_X_W,
  parameter int Y_W = POS_Y_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              sample,
  input  logic [DATA_W-1:0] data,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic [DATA_W-1:0] thresh,
  output logic [DATA_W-1:0] max_val,
  output logic [X_W-1:0]    max_x,
  output logic [Y_W-1:0]    max_y,
  output logic              found
);
  logic [DATA_W-1:0] ref_val;
  logic              hit;

  // clear and sample can coincide on the first cycle of a frame; the
  // pixel is then compared against an empty tracker, not the old peak.
  always_comb begin
    ref_val = clear ? '0 : max_val;
    hit     = sample && (data >= thresh) && (data > ref_val);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_val <= '0;
      max_x   <= '0;
      max_y   <= '0;
      found   <= 1'b0;
    end else if (hit) begin
      max_val <= data;
      max_x   <= x;
      max_y   <= y;
      found   <= 1'b1;
    end else if (clear) begin
      max_val <= '0;
      max_x   <= '0;
      max_y   <= '0;
      found   <= 1'b0;
    end
  end
endmodule

// File: rtl/camera_stream_conditioner.sv
// Conditions the D5M camera stream for the video_ext input.
// Only complete, geometry-checked frames reach the system, and the brightest
// pixel above thresh is reported once per good frame.
// Ports:
//   clk, reset_n                    pixel clock, asynchronous active-low reset
//   enable                          allows new frames to start
//   thresh                          minimum pixel level for the tracker
//   cam_data/cam_lval/cam_fval      raw camera pins
//   out_data/out_lval/out_fval      to video_ext, two cycles behind cam_*
//   pos_x/pos_y/pos_level           peak pixel of the last good frame
//   pos_valid                       one-cycle pulse, new position available
//   frame_err                       one-cycle pulse, frame failed geometry check
//   frames_ok/frames_bad            wrapping frame counters
module camera_stream_conditioner
  import camera_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [DATA_W-1:0]  thresh,
  input  logic [DATA_W-1:0]  cam_data,
  input  logic               cam_lval,
  input  logic               cam_fval,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_lval,
  output logic               out_fval,
  output logic [POS_X_W-1:0] pos_x,
  output logic [POS_Y_W-1:0] pos_y,
  output logic [DATA_W-1:0]  pos_level,
  output logic               pos_valid,
  output logic               frame_err,
  output logic [CNT_W-1:0]   frames_ok,
  output logic [CNT_W-1:0]   frames_bad
);
  localparam int PC_W = $clog2(H_ACTIVE + 1);
  localparam int LC_W = $clog2(V_ACTIVE + 1);
  localparam logic [PC_W-1:0] H_LIM = PC_W'(H_ACTIVE);
  localparam logic [LC_W-1:0] V_LIM = LC_W'(V_ACTIVE);

  logic [DATA_W-1:0] s1_data;
  logic              s1_lval, s1_fval, p_lval, p_fval;
  state_t            state, state_next;
  logic [PC_W-1:0]   pix_cnt, pix_next, pc_base;
  logic [LC_W-1:0]   line_cnt, line_next, lc_base;
  logic              err, err_next, err_base;
  logic              sof, eol, eof, start, in_frame, pixel, in_win;
  logic              frame_done, frame_good;

  logic [DATA_W-1:0]  max_val;
  logic [POS_X_W-1:0] max_x;
  logic [POS_Y_W-1:0] max_y;
  logic               found;

  always_comb begin
    sof      = s1_fval & ~p_fval;
    eol      = p_lval & ~s1_lval;
    eof      = p_fval & ~s1_fval;
    start    = (state == WAIT_SOF) & sof & enable;
    in_frame = (state == ACTIVE) | start;
    // On the SOF cycle the frame already runs from cleared counters, so a
    // line starting together with the frame is counted and passed.
    pc_base  = start ? '0 : pix_cnt;
    lc_base  = start ? '0 : line_cnt;
    err_base = start ? 1'b0 : err;
    pixel    = in_frame & s1_fval & s1_lval;
    in_win   = (pc_base < H_LIM) && (lc_base < V_LIM);

    state_next = state;
    pix_next   = pc_base;
    line_next  = lc_base;
    err_next   = err_base;
    frame_done = 1'b0;
    frame_good = 1'b0;

    if (start) state_next = ACTIVE;
    if (pixel) begin
      if (!in_win) err_next = 1'b1;
      if (pc_base != H_LIM) pix_next = pc_base + 1'b1;
    end
    if ((state == ACTIVE) && eol) begin
      if (pc_base != H_LIM) err_next = 1'b1;
      if (lc_base != V_LIM) line_next = lc_base + 1'b1;
      pix_next = '0;
    end
    // EOF uses the post-EOL line count, so a line closing in the EOF cycle counts.
    if ((state == ACTIVE) && eof) begin
      frame_done = 1'b1;
      frame_good = !err_next && (line_next == V_LIM);
      state_next = WAIT_SOF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= WAIT_SOF;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_data    <= '0;
      s1_lval    <= 1'b0;
      // fval history starts high so a frame already running at reset
      // release shows no rising edge and is dropped whole.
      s1_fval    <= 1'b1;
      p_lval     <= 1'b0;
      p_fval     <= 1'b1;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      err        <= 1'b0;
      out_data   <= '0;
      out_lval   <= 1'b0;
      out_fval   <= 1'b0;
      pos_x      <= '0;
      pos_y      <= '0;
      pos_level  <= '0;
      pos_valid  <= 1'b0;
      frame_err  <= 1'b0;
      frames_ok  <= '0;
      frames_bad <= '0;
    end else begin
      s1_data   <= cam_data;
      s1_lval   <= cam_lval;
      s1_fval   <= cam_fval;
      p_lval    <= s1_lval;
      p_fval    <= s1_fval;
      pix_cnt   <= pix_next;
      line_cnt  <= line_next;
      err       <= err_next;
      out_fval  <= in_frame & s1_fval;
      out_lval  <= pixel & in_win;
      out_data  <= in_frame ? s1_data : '0;
      pos_valid <= 1'b0;
      frame_err <= 1'b0;
      if (frame_done) begin
        if (frame_good) begin
          frames_ok <= frames_ok + 1'b1;
          if (found) begin
            pos_valid <= 1'b1;
            pos_x     <= max_x;
            pos_y     <= max_y;
            pos_level <= max_val;
          end
        end else begin
          frames_bad <= frames_bad + 1'b1;
          frame_err  <= 1'b1;
        end
      end
    end
  end

  peak_pixel_tracker #(
    .X_W(POS_X_W),
    .Y_W(POS_Y_W)
  ) u_tracker (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (start),
    .sample (pixel & in_win),
    .data   (s1_data),
    .x      (POS_X_W'(pc_base)),
    .y      (POS_Y_W'(lc_base)),
    .thresh (thresh),
    .max_val(max_val),
    .max_x  (max_x),
    .max_y  (max_y),
    .found  (found)
  );
endmodule

// File: tb/tb_camera_stream_conditioner.sv
module tb_camera_stream_conditioner;
  import camera_pkg::*;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int CW = 16;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b1;
  logic [DATA_W-1:0]  thresh = '0;
  logic [DATA_W-1:0]  cam_data = '0;
  logic               cam_lval = 1'b0;
  logic               cam_fval = 1'b0;
  logic [DATA_W-1:0]  out_data;
  logic               out_lval, out_fval;
  logic [POS_X_W-1:0] pos_x;
  logic [POS_Y_W-1:0] pos_y;
  logic [DATA_W-1:0]  pos_level;
  logic               pos_valid, frame_err;
  logic [CW-1:0]      frames_ok, frames_bad;

  camera_stream_conditioner #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .thresh    (thresh),
    .cam_data  (cam_data),
    .cam_lval  (cam_lval),
    .cam_fval  (cam_fval),
    .out_data  (out_data),
    .out_lval  (out_lval),
    .out_fval  (out_fval),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .pos_level (pos_level),
    .pos_valid (pos_valid),
    .frame_err (frame_err),
    .frames_ok (frames_ok),
    .frames_bad(frames_bad)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              f;
    logic              l;
    logic [DATA_W-1:0] d;
  } pix_t;

  typedef struct packed {
    logic [POS_X_W-1:0] x;
    logic [POS_Y_W-1:0] y;
    logic [DATA_W-1:0]  lvl;
  } pos_t;

  pix_t out_q[$];
  pos_t pos_q[$];
  int   checks = 0, errors = 0;
  int   pos_pulses = 0, err_pulses = 0;
  int   exp_ok = 0, exp_bad = 0, exp_pos = 0, exp_err = 0;
  pos_t held = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pixval(input int mode, input int ln, input int c);
    if (mode == 0) return DATA_W'(ln * 8 + c);
    if (mode == 1) return DATA_W'(50);
    if ((ln == 1 && c == 2) || (ln == 3 && c == 5)) return DATA_W'(500);
    return DATA_W'(10);
  endfunction

  // One clock of stimulus: drive, push expectation, check the output of two steps ago.
  task automatic step(input logic f, input logic l, input logic [DATA_W-1:0] d,
                      input logic ef, input logic el);
    pix_t e;
    pos_t p;
    cam_fval = f;
    cam_lval = l;
    cam_data = d;
    e.f = ef;
    e.l = el;
    e.d = d;
    out_q.push_back(e);
    @(negedge clk);
    if (out_q.size() == 3) begin
      e = out_q.pop_front();
      chk("out_fval", {31'd0, out_fval}, {31'd0, e.f});
      chk("out_lval", {31'd0, out_lval}, {31'd0, e.l});
      if (e.l) chk("out_data", 32'(out_data), 32'(e.d));
    end
    if (pos_valid) begin
      pos_pulses++;
      if (pos_q.size() > 0) begin
        p = pos_q.pop_front();
        chk("pos_x", 32'(pos_x), 32'(p.x));
        chk("pos_y", 32'(pos_y), 32'(p.y));
        chk("pos_level", 32'(pos_level), 32'(p.lvl));
      end
    end
    if (frame_err) err_pulses++;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int lines, input int long_line, input int mode,
                       input bit pass, input bit same, input int gap);
    int len;
    step(1'b1, 1'b0, '0, pass, 1'b0);
    for (int ln = 0; ln < lines; ln++) begin
      len = (ln == long_line) ? H + 1 : H;
      for (int c = 0; c < len; c++)
        step(1'b1, 1'b1, pixval(mode, ln, c), pass, pass && (c < H) && (ln < V));
      if (!(same && ln == lines - 1)) begin
        step(1'b1, 1'b0, '0, pass, 1'b0);
        step(1'b1, 1'b0, '0, pass, 1'b0);
      end
    end
    for (int g = 0; g < gap; g++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, ".frames_ok"}, 32'(frames_ok), 32'(exp_ok));
    chk({tag, ".frames_bad"}, 32'(frames_bad), 32'(exp_bad));
    chk({tag, ".pos_pulses"}, 32'(pos_pulses), 32'(exp_pos));
    chk({tag, ".err_pulses"}, 32'(err_pulses), 32'(exp_err));
    chk({tag, ".pos_pending"}, 32'(pos_q.size()), 32'd0);
    chk({tag, ".held_x"}, 32'(pos_x), 32'(held.x));
    chk({tag, ".held_y"}, 32'(pos_y), 32'(held.y));
    chk({tag, ".held_lvl"}, 32'(pos_level), 32'(held.lvl));
  endtask

  task automatic expect_pos(input int x, input int y, input int lvl);
    pos_t p;
    p.x = POS_X_W'(x);
    p.y = POS_Y_W'(y);
    p.lvl = DATA_W'(lvl);
    pos_q.push_back(p);
    held = p;
    exp_pos++;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_fval", {31'd0, out_fval}, 32'd0);
    chk("rst.out_lval", {31'd0, out_lval}, 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.pos_valid", {31'd0, pos_valid}, 32'd0);
    chk("rst.frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst.frames_ok", 32'(frames_ok), 32'd0);
    chk("rst.frames_bad", 32'(frames_bad), 32'd0);
    chk("rst.pos", 32'({pos_x, pos_y, pos_level}), 32'd0);
    reset_n = 1'b1;
    repeat (2) step(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // 1: clean ramp frame, peak at the last pixel
    expect_pos(7, 3, 31);
    exp_ok++;
    frame(4, -1, 0, 1'b1, 1'b0, 4);
    checkpoint("t1");

    // 2: reset mid-frame, then a frame already running at release is dropped
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int c = 0; c < H; c++) step(1'b1, 1'b1, DATA_W'(c), 1'b1, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t2.async_fval", {31'd0, out_fval}, 32'd0);
    chk("t2.async_lval", {31'd0, out_lval}, 32'd0);
    chk("t2.async_ok", 32'(frames_ok), 32'd0);
    cam_lval = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    out_q.delete();
    pos_q.delete();
    exp_ok = 0; exp_bad = 0; exp_pos = 0; exp_err = 0;
    pos_pulses = 0; err_pulses = 0;
    held = '0;
    reset_n = 1'b1;
    frame(4, -1, 0, 1'b0, 1'b0, 4);
    checkpoint("t2a");
    expect_pos(7, 3, 31);
    exp_ok++;
    frame(4, -1, 0, 1'b1, 1'b0, 4);
    checkpoint("t2b");

    // 3: one over-long line, then a clean frame
    exp_bad++;
    exp_err++;
    frame(4, 2, 0, 1'b1, 1'b0, 4);
    checkpoint("t3a");
    expect_pos(7, 3, 31);
    exp_ok++;
    frame(4, -1, 0, 1'b1, 1'b0, 4);
    checkpoint("t3b");

    // 4: short frame, then a frame entirely below threshold
    exp_bad++;
    exp_err++;
    frame(3, -1, 0, 1'b1, 1'b0, 4);
    checkpoint("t4a");
    thresh = DATA_W'(100);
    exp_ok++;
    frame(4, -1, 1, 1'b1, 1'b0, 4);
    checkpoint("t4b");

    // 5: tie between two peaks, then a frame blocked by enable=0
    expect_pos(2, 1, 500);
    exp_ok++;
    frame(4, -1, 2, 1'b1, 1'b0, 4);
    checkpoint("t5a");
    enable = 1'b0;
    frame(4, -1, 0, 1'b0, 1'b0, 4);
    checkpoint("t5b");
    enable = 1'b1;

    // 6: EOL and EOF together, followed by a back-to-back frame
    thresh = '0;
    expect_pos(7, 3, 31);
    expect_pos(7, 3, 31);
    exp_ok += 2;
    frame(4, -1, 0, 1'b1, 1'b1, 1);
    frame(4, -1, 0, 1'b1, 1'b0, 4);
    checkpoint("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
